// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions for the fetch stage: FSM encodings, PC step and
// instruction field bit positions.
package cpu_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface instr_fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/instr_fetch_fields.sv
// Purely combinational decode of a captured instruction word into its fields.
import cpu_pkg::*;

module instr_fields (
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] imm16
);

    assign opcode = instr[OPCODE_HI:OPCODE_LO];
    assign rs     = instr[RS_HI:RS_LO];
    assign rt     = instr[RT_HI:RT_LO];
    assign rd     = instr[RD_HI:RD_LO];
    assign funct  = instr[FUNCT_HI:FUNCT_LO];
    assign imm16  = instr[IMM_HI:IMM_LO];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: two-state FETCH/HOLD FSM with branch redirect.
// Optional ack timeout with sticky error is enabled by FETCH_TIMEOUT_EN.
import cpu_pkg::*;

module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    instr_fetch_if.master        imem,
    output logic                 instr_valid,
    output logic [31:0]          instr,
    output logic [31:0]          pc_out,
    output logic [5:0]           opcode,
    output logic [4:0]           rs,
    output logic [4:0]           rt,
    output logic [4:0]           rd,
    output logic [5:0]           funct,
    output logic [15:0]          imm16,
    output logic                 fetch_err
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  instr_next, pc_out_next;
    logic         redirect_pending, pend_next;
    logic [31:0]  pend_target, pend_target_next;

    // A zero timeout would fire every cycle; keep that configuration visibly inert.
    if (TIMEOUT_CYCLES == 0) begin : g_zero_timeout
    end

    assign imem.req    = (state == FETCH) && !rst;
    assign imem.addr   = pc;
    assign instr_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= FETCH;
            pc               <= RESET_PC;
            instr            <= '0;
            pc_out           <= '0;
            redirect_pending <= 1'b0;
            pend_target      <= '0;
        end else begin
            state            <= state_next;
            pc               <= pc_next;
            instr            <= instr_next;
            pc_out           <= pc_out_next;
            redirect_pending <= pend_next;
            pend_target      <= pend_target_next;
        end
    end

    // An ack that coincides with, or follows, a redirect belongs to the old
    // path and is dropped; the newest branch target always wins.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instr_next       = instr;
        pc_out_next      = pc_out;
        pend_next        = redirect_pending;
        pend_target_next = pend_target;
        unique case (state)
            FETCH: begin
                if (imem.ack) begin
                    pend_next = 1'b0;
                    if (branch_taken) begin
                        pc_next = align_word(branch_target);
                    end else if (redirect_pending) begin
                        pc_next = pend_target;
                    end else begin
                        instr_next  = imem.rdata;
                        pc_out_next = pc;
                        state_next  = HOLD;
                    end
                end else if (branch_taken) begin
                    pend_next        = 1'b1;
                    pend_target_next = align_word(branch_target);
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_next    = align_word(branch_target);
                    state_next = FETCH;
                end else if (!stall) begin
                    pc_next    = pc + PC_STEP;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

`ifdef FETCH_TIMEOUT_EN
    logic [31:0] tmo_cnt, tmo_cnt_next;
    logic        err_q, err_next;

    // Counts unanswered FETCH cycles; on expiry the request simply restarts
    // at the same pc and the error stays latched until reset.
    always_comb begin
        tmo_cnt_next = '0;
        err_next     = err_q;
        if (state == FETCH && !imem.ack) begin
            if (tmo_cnt + 32'd1 >= TIMEOUT_CYCLES) begin
                tmo_cnt_next = '0;
                err_next     = 1'b1;
            end else begin
                tmo_cnt_next = tmo_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            tmo_cnt <= tmo_cnt_next;
            err_q   <= err_next;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    instr_fields u_fields (
        .instr  (instr),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .funct  (funct),
        .imm16  (imm16)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; a second instance with
// RESET_PC at the top word checks address wrap-around.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;

    logic        instr_valid, fetch_err;
    logic [31:0] instr, pc_out;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;

    logic        w_valid, w_err;
    logic [31:0] w_instr, w_pc_out;
    logic [5:0]  w_opcode, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [15:0] w_imm16;
    logic        w_stall = 1'b0;
    logic        w_branch = 1'b0;
    logic [31:0] w_target = '0;

    int checks = 0;
    int errors = 0;

    instr_fetch_if imem_bus ();
    instr_fetch_if wrap_bus ();

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem_bus),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .pc_out        (pc_out),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .funct         (funct),
        .imm16         (imm16),
        .fetch_err     (fetch_err)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk           (clk),
        .rst           (rst),
        .stall         (w_stall),
        .branch_taken  (w_branch),
        .branch_target (w_target),
        .imem          (wrap_bus),
        .instr_valid   (w_valid),
        .instr         (w_instr),
        .pc_out        (w_pc_out),
        .opcode        (w_opcode),
        .rs            (w_rs),
        .rt            (w_rt),
        .rd            (w_rd),
        .funct         (w_funct),
        .imm16         (w_imm16),
        .fetch_err     (w_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic br, input logic [31:0] tgt,
                                 input logic ack, input logic [31:0] rdata);
        stall              = st;
        branch_taken       = br;
        branch_target      = tgt;
        imem_bus.ack       = ack;
        imem_bus.rdata     = rdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        logic expect_err;
        wrap_bus.ack   = 1'b1;
        wrap_bus.rdata = 32'h1234_5678;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        tick();
        tick();
        checkOutput("rst_req", {31'b0, imem_bus.req}, 32'd0);
        checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_pc_out", pc_out, 32'h0);
        checkOutput("rst_err", {31'b0, fetch_err}, 32'd0);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h2002_0B34);
        rst = 1'b0;
        #1;
        checkOutput("first_req", {31'b0, imem_bus.req}, 32'd1);
        checkOutput("first_addr", imem_bus.addr, 32'h0);
        checkOutput("wrap_first_addr", wrap_bus.addr, 32'hFFFF_FFFC);

        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("cap_valid", {31'b0, instr_valid}, 32'd1);
        checkOutput("cap_instr", instr, 32'h2002_0B34);
        checkOutput("cap_imm16", imm16, 32'h0B34);
        checkOutput("cap_rt", rt, 32'd2);
        checkOutput("cap_opcode", opcode, 32'h08);
        checkOutput("cap_pc_out", pc_out, 32'h0);
        checkOutput("wrap_pc_out", w_pc_out, 32'hFFFF_FFFC);

        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_valid", {31'b0, instr_valid}, 32'd1);
            checkOutput("stall_instr", instr, 32'h2002_0B34);
            checkOutput("stall_pc_out", pc_out, 32'h0);
            checkOutput("stall_req", {31'b0, imem_bus.req}, 32'd0);
            if (i == 0) begin
                checkOutput("wrap_second_addr", wrap_bus.addr, 32'h0);
                checkOutput("wrap_second_req", {31'b0, wrap_bus.req}, 32'd1);
            end
        end

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checkOutput("resume_addr", imem_bus.addr, 32'h4);
        checkOutput("resume_req", {31'b0, imem_bus.req}, 32'd1);
        checkOutput("resume_valid", {31'b0, instr_valid}, 32'd0);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h012A_5820);
        tick();
        checkOutput("r_rs", rs, 32'd9);
        checkOutput("r_rd", rd, 32'd11);
        checkOutput("r_funct", funct, 32'h20);
        checkOutput("r_pc_out", pc_out, 32'h4);

        applyStimulus(1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("hold_branch_addr", imem_bus.addr, 32'h0000_0100);
        checkOutput("hold_branch_valid", {31'b0, instr_valid}, 32'd0);

        applyStimulus(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("pend_addr_held", imem_bus.addr, 32'h0000_0100);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        tick();
        checkOutput("drop_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("drop_addr", imem_bus.addr, 32'h0000_0040);
        checkOutput("drop_instr", instr, 32'h012A_5820);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8C88_0004);
        tick();
        checkOutput("lw_pc_out", pc_out, 32'h0000_0040);
        checkOutput("lw_opcode", opcode, 32'h23);
        checkOutput("lw_rt", rt, 32'd8);
        checkOutput("lw_imm16", imm16, 32'h0004);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'hCAFE_0000);
        tick();
        checkOutput("ack_branch_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("ack_branch_addr", imem_bus.addr, 32'h0000_0200);
        checkOutput("ack_branch_instr", instr, 32'h8C88_0004);

        applyStimulus(1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0407, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0001);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("latest_addr", imem_bus.addr, 32'h0000_0404);
        checkOutput("latest_valid", {31'b0, instr_valid}, 32'd0);

`ifdef FETCH_TIMEOUT_EN
        expect_err = 1'b1;
        repeat (15) tick();
        checkOutput("tmo_before", {31'b0, fetch_err}, 32'd0);
        tick();
        checkOutput("tmo_err", {31'b0, fetch_err}, 32'd1);
`else
        expect_err = 1'b0;
        repeat (20) tick();
        checkOutput("no_tmo_err", {31'b0, fetch_err}, 32'd0);
`endif
        checkOutput("tmo_req", {31'b0, imem_bus.req}, 32'd1);
        checkOutput("tmo_addr", imem_bus.addr, 32'h0000_0404);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h03E0_0008);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("late_valid", {31'b0, instr_valid}, 32'd1);
        checkOutput("late_pc_out", pc_out, 32'h0000_0404);
        checkOutput("late_rs", rs, 32'd31);
        checkOutput("late_funct", funct, 32'h08);
        checkOutput("late_err", {31'b0, fetch_err}, {31'b0, expect_err});

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        checkOutput("final_addr", imem_bus.addr, 32'h0000_0408);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
